// File: rtl/img_pixel_streamer_pkg.sv
// Shared frame geometry and streamer FSM encoding. The conv1 line buffer
// imports the same geometry so both ends agree on the frame size.
package img_pixel_streamer_pkg;

  localparam int unsigned ImgWidth  = 28;
  localparam int unsigned ImgHeight = 28;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StWait   = 2'd2,
    StStream = 2'd3
  } state_e;

endpackage

// File: rtl/img_pixel_streamer.sv
// Reads a binary image one row word at a time and emits it as a gapless 1-bit
// raster stream, prefetching the next row while the current one is shifted out.
module img_pixel_streamer
  import img_pixel_streamer_pkg::*;
#(
  parameter int unsigned WIDTH     = ImgWidth,
  parameter int unsigned HEIGHT    = ImgHeight,
  parameter int unsigned ADDR_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [WIDTH-1:0]     mem_rd_data,
  output logic                 pixel_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned XBits = $clog2(WIDTH);
  localparam logic [XBits-1:0]     XLast = XBits'(WIDTH - 1);
  localparam logic [XBits-1:0]     XOne  = XBits'(1);
  localparam logic [ADDR_BITS-1:0] YLast = ADDR_BITS'(HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] YOne  = ADDR_BITS'(1);

  state_e                 state_q, state_d;
  logic [XBits-1:0]       x_q, x_d;
  logic [ADDR_BITS-1:0]   y_q, y_d;
  logic [WIDTH-1:0]       cur_row_q, cur_row_d;
  logic [WIDTH-1:0]       nxt_row_q, nxt_row_d;
  logic                   pend_q, pend_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   pixel_q, pixel_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       nxt_row_fwd;

  // With WIDTH=3 the prefetch capture lands on the same edge as the row swap,
  // so the swap must take the word straight from the memory port.
  assign nxt_row_fwd = pend_q ? mem_rd_data : nxt_row_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cur_row_d = cur_row_q;
    nxt_row_d = nxt_row_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    pixel_d   = 1'b0;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Prefetch data arrives two edges after the read strobe is raised.
    pend_d = rd_en_q && (state_q == StStream);
    if (pend_q) begin
      nxt_row_d = mem_rd_data;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          rd_en_d = 1'b1;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      StFetch: begin
        state_d = StWait;
      end
      StWait: begin
        cur_row_d = mem_rd_data;
        x_d       = '0;
        y_d       = '0;
        state_d   = StStream;
      end
      StStream: begin
        if (!hold) begin
          valid_d = 1'b1;
          pixel_d = cur_row_q[x_q];
          if ((x_q == '0) && (y_q != YLast)) begin
            rd_en_d = 1'b1;
            addr_d  = y_q + YOne;
          end
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end else begin
              y_d       = y_q + YOne;
              cur_row_d = nxt_row_fwd;
            end
          end else begin
            x_d = x_q + XOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      cur_row_q <= '0;
      nxt_row_q <= '0;
      pend_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      pixel_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cur_row_q <= cur_row_d;
      nxt_row_q <= nxt_row_d;
      pend_q    <= pend_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      pixel_q   <= pixel_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign pixel_out  = pixel_q;
  assign valid_out  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_img_pixel_streamer.sv
// Self-checking bench for img_pixel_streamer: 28x28 instance plus a 3x1 instance.
module tb_img_pixel_streamer;

  localparam int W      = 28;
  localparam int H      = 28;
  localparam int N      = W * H;
  localparam int MaxCyc = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, hold;
  logic         mem_rd_en;
  logic [4:0]   mem_addr;
  logic [W-1:0] mem_rd_data;
  logic         pixel_out, valid_out, busy, frame_done;
  logic [W-1:0] img [H];

  logic         s_start, s_hold, s_re, s_pix, s_valid, s_busy, s_done;
  logic [0:0]   s_addr;
  logic [2:0]   s_rdata, s_img;

  int n_cmp = 0;
  int n_bad = 0;

  // Recorded outputs of the large instance, indexed by cycle since start.
  logic r_v [MaxCyc];
  logic r_p [MaxCyc];
  logic r_fd[MaxCyc];
  logic r_b [MaxCyc];
  logic r_re[MaxCyc];
  logic r_h [MaxCyc];
  int   r_ad[MaxCyc];

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= img[mem_addr];
  always @(posedge clk) if (s_re) s_rdata <= s_img;

  img_pixel_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold       (hold),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .pixel_out  (pixel_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  img_pixel_streamer #(.WIDTH(3), .HEIGHT(1)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .hold       (s_hold),
    .mem_rd_en  (s_re),
    .mem_addr   (s_addr),
    .mem_rd_data(s_rdata),
    .pixel_out  (s_pix),
    .valid_out  (s_valid),
    .busy       (s_busy),
    .frame_done (s_done)
  );

  // Drives start/hold and records outputs; entered and left at posedge+1.
  task automatic run_cycles(input int n, input int hold_pct, input bit start_always);
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || start_always;
      hold  = ($urandom_range(99) < hold_pct);
      @(negedge clk);
      r_v[c]  = valid_out;
      r_p[c]  = pixel_out;
      r_fd[c] = frame_done;
      r_b[c]  = busy;
      r_re[c] = mem_rd_en;
      r_ad[c] = int'(mem_addr);
      r_h[c]  = hold;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++) img[y] = W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; s_start = 1'b0; s_hold = 1'b0; s_img = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_cmp++; if (pixel_out !== 1'b0) begin n_bad++; $display("FAIL reset_pixel got %b want 0", pixel_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", frame_done); end
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    n_cmp++; if (mem_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    n_cmp++; if ({s_valid, s_pix, s_busy, s_done, s_re} !== 5'b0) begin
      n_bad++; $display("FAIL reset_small got %b want 00000", {s_valid, s_pix, s_busy, s_done, s_re});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_checkerboard();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'((x + y) & 1);
    run_cycles(792, 0, 1'b0);
    for (int c = 0; c < 792; c++) begin
      logic ev, ep, efd, eb;
      int   idx;
      ev  = (c >= 4) && (c <= 787);
      idx = c - 4;
      ep  = ev ? 1'(((idx % W) + (idx / W)) & 1) : 1'b0;
      efd = (c == 787);
      eb  = (c >= 1) && (c <= 786);
      n_cmp++; if (r_v[c] !== ev) begin n_bad++; $display("FAIL cb_valid cyc %0d got %b want %b", c, r_v[c], ev); end
      n_cmp++; if (r_p[c] !== ep) begin n_bad++; $display("FAIL cb_pixel cyc %0d got %b want %b", c, r_p[c], ep); end
      n_cmp++; if (r_fd[c] !== efd) begin n_bad++; $display("FAIL cb_done cyc %0d got %b want %b", c, r_fd[c], efd); end
      n_cmp++; if (r_b[c] !== eb) begin n_bad++; $display("FAIL cb_busy cyc %0d got %b want %b", c, r_b[c], eb); end
    end
  endtask

  task automatic test_mem_reads();
    int nr, rc[H], ra[H];
    for (int y = 0; y < H; y++) img[y] = (W'($urandom) & ~W'(31)) | W'(y);
    run_cycles(792, 0, 1'b0);
    nr = 0;
    for (int c = 0; c < 792; c++) begin
      if (r_re[c]) begin
        if (nr < H) begin rc[nr] = c; ra[nr] = r_ad[c]; end
        nr++;
      end
    end
    n_cmp++; if (nr !== H) begin n_bad++; $display("FAIL rd_count got %0d want %0d", nr, H); end
    for (int k = 0; k < H && k < nr; k++) begin
      int ec;
      ec = (k == 0) ? 1 : 4 + (k - 1) * W;
      n_cmp++; if (rc[k] !== ec) begin n_bad++; $display("FAIL rd_cycle %0d got %0d want %0d", k, rc[k], ec); end
      n_cmp++; if (ra[k] !== k) begin n_bad++; $display("FAIL rd_addr %0d got %0d want %0d", k, ra[k], k); end
    end
    for (int c = 4; c <= 787; c++) begin
      logic ep;
      ep = img[(c - 4) / W][(c - 4) % W];
      n_cmp++; if (r_v[c] !== 1'b1 || r_p[c] !== ep) begin
        n_bad++; $display("FAIL rd_pixel cyc %0d got v=%b p=%b want v=1 p=%b", c, r_v[c], r_p[c], ep);
      end
    end
  endtask

  task automatic test_random_hold();
    int p, held, last, dut_last;
    fill_random();
    run_cycles(1400, 30, 1'b0);
    p = 0; held = 0; last = -1; dut_last = -1;
    for (int c = 0; c < 1400; c++) begin
      logic ev, ep;
      ev = 1'b0; ep = 1'b0;
      if (c >= 4 && p < N) begin
        if (r_h[c-1]) held++;
        else begin
          ev = 1'b1; ep = img[p / W][p % W]; p++;
          if (p == N) last = c;
        end
      end
      if (r_fd[c] && dut_last < 0) dut_last = c;
      n_cmp++; if (r_v[c] !== ev) begin n_bad++; $display("FAIL hold_valid cyc %0d got %b want %b", c, r_v[c], ev); end
      n_cmp++; if (r_p[c] !== ep) begin n_bad++; $display("FAIL hold_pixel cyc %0d got %b want %b", c, r_p[c], ep); end
      n_cmp++; if (r_fd[c] !== (c == last)) begin
        n_bad++; $display("FAIL hold_done cyc %0d got %b want %b", c, r_fd[c], (c == last));
      end
    end
    n_cmp++; if (dut_last !== 4 + N - 1 + held) begin
      n_bad++; $display("FAIL hold_length got last=%0d want %0d (held %0d)", dut_last, 4 + N - 1 + held, held);
    end
  endtask

  task automatic test_small();
    s_img = 3'($urandom);
    for (int c = 0; c < 10; c++) begin
      logic ev, ep;
      s_start = (c == 0);
      s_hold  = 1'b0;
      @(negedge clk);
      ev = (c >= 4) && (c <= 6);
      ep = ev ? s_img[c - 4] : 1'b0;
      n_cmp++; if (s_valid !== ev) begin n_bad++; $display("FAIL small_valid cyc %0d got %b want %b", c, s_valid, ev); end
      n_cmp++; if (s_pix !== ep) begin n_bad++; $display("FAIL small_pixel cyc %0d got %b want %b", c, s_pix, ep); end
      n_cmp++; if (s_done !== (c == 6)) begin n_bad++; $display("FAIL small_done cyc %0d got %b want %b", c, s_done, (c == 6)); end
      n_cmp++; if (s_re !== (c == 1)) begin n_bad++; $display("FAIL small_rd_en cyc %0d got %b want %b", c, s_re, (c == 1)); end
      n_cmp++; if (s_busy !== (c >= 1 && c <= 5)) begin
        n_bad++; $display("FAIL small_busy cyc %0d got %b want %b", c, s_busy, (c >= 1 && c <= 5));
      end
      if (s_re) begin
        n_cmp++; if (s_addr !== 1'b0) begin n_bad++; $display("FAIL small_addr got %0d want 0", s_addr); end
      end
      @(posedge clk); #1;
    end
    s_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_cycles(900, 0, 1'b1);
    for (int c = 0; c < 900; c++) begin
      int   rel;
      logic ev, ep, ere, eb;
      rel = (c > 787) ? c - 787 : c;
      ev  = (rel >= 4) && (rel <= 787);
      ep  = ev ? img[(rel - 4) / W][(rel - 4) % W] : 1'b0;
      ere = (rel == 1) || (rel >= 4 && ((rel - 4) % W) == 0 && ((rel - 4) / W) < H - 1);
      eb  = (c > 787) ? (rel >= 1) : (c >= 1 && c <= 786);
      n_cmp++; if (r_re[c] !== ere) begin n_bad++; $display("FAIL b2b_rd_en cyc %0d got %b want %b", c, r_re[c], ere); end
      if (ere) begin
        int ea;
        ea = (rel == 1) ? 0 : (rel - 4) / W + 1;
        n_cmp++; if (r_ad[c] !== ea) begin n_bad++; $display("FAIL b2b_addr cyc %0d got %0d want %0d", c, r_ad[c], ea); end
      end
      n_cmp++; if (r_v[c] !== ev || r_p[c] !== ep) begin
        n_bad++; $display("FAIL b2b_pixel cyc %0d got v=%b p=%b want v=%b p=%b", c, r_v[c], r_p[c], ev, ep);
      end
      n_cmp++; if (r_b[c] !== eb) begin n_bad++; $display("FAIL b2b_busy cyc %0d got %b want %b", c, r_b[c], eb); end
      n_cmp++; if (r_fd[c] !== (c == 787)) begin
        n_bad++; $display("FAIL b2b_done cyc %0d got %b want %b", c, r_fd[c], (c == 787));
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycles(154, 0, 1'b0);
    n_cmp++; if (valid_out !== 1'b1 || pixel_out !== img[5][10]) begin
      n_bad++; $display("FAIL mid_pre_pixel got v=%b p=%b want v=1 p=%b", valid_out, pixel_out, img[5][10]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({valid_out, pixel_out, busy, frame_done, mem_rd_en, mem_addr} !== 10'b0) begin
      n_bad++; $display("FAIL mid_async_zero got %b want 0", {valid_out, pixel_out, busy, frame_done, mem_rd_en, mem_addr});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if ({valid_out, pixel_out, busy, frame_done, mem_rd_en, mem_addr} !== 10'b0) begin
        n_bad++; $display("FAIL mid_held_zero %0d got %b want 0", k, {valid_out, pixel_out, busy, frame_done, mem_rd_en, mem_addr});
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycles(792, 0, 1'b0);
    for (int c = 0; c < 792; c++) begin
      logic ev, ep;
      ev = (c >= 4) && (c <= 787);
      ep = ev ? img[(c - 4) / W][(c - 4) % W] : 1'b0;
      n_cmp++; if (r_v[c] !== ev || r_p[c] !== ep) begin
        n_bad++; $display("FAIL mid_frame cyc %0d got v=%b p=%b want v=%b p=%b", c, r_v[c], r_p[c], ev, ep);
      end
      n_cmp++; if (r_fd[c] !== (c == 787)) begin
        n_bad++; $display("FAIL mid_done cyc %0d got %b want %b", c, r_fd[c], (c == 787));
      end
    end
    n_cmp++; if (r_re[1] !== 1'b1 || r_ad[1] !== 0) begin
      n_bad++; $display("FAIL mid_first_read got en=%b addr=%0d want en=1 addr=0", r_re[1], r_ad[1]);
    end
  endtask

  initial begin
    test_reset();
    test_checkerboard();
    test_mem_reads();
    test_random_hold();
    test_small();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
